// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared mode encodings and defaults for the audio tone generator
package audio_pkg;

    localparam int AUDIO_BITS_DEF = 12;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    localparam logic [1:0] MODE_SQR  = 2'd3;

endpackage

// File: rtl/audio_channel_gen.sv
// rtl/audio_channel_gen.sv - per-channel waveform value and triangle direction register
module audio_channel_gen
    import audio_pkg::*;
#(
    parameter int                    AUDIO_BITS  = AUDIO_BITS_DEF,
    parameter logic [AUDIO_BITS-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  load,
    input  logic                  dir_reset,
    input  logic [1:0]            mode,
    input  logic [AUDIO_BITS-1:0] step,
    output logic [AUDIO_BITS-1:0] value
);

    localparam logic [AUDIO_BITS-1:0] MAX   = '1;
    localparam logic [AUDIO_BITS:0]   MAX_W = {1'b0, MAX};

    logic                  down;
    logic                  next_down;
    logic [AUDIO_BITS-1:0] next_value;
    logic [AUDIO_BITS:0]   sum;

    // One extra bit so the triangle peak compare cannot wrap
    assign sum = {1'b0, value} + {1'b0, step};

    always_comb begin
        next_value = value;
        next_down  = dir_reset ? 1'b0 : down;
        case (mode)
            MODE_SAW: next_value = value + step;
            MODE_TRI: begin
                // A zero step freezes the waveform, including its direction
                if (step != '0) begin
                    if (!next_down) begin
                        if (sum >= MAX_W) begin
                            next_value = MAX;
                            next_down  = 1'b1;
                        end else begin
                            next_value = sum[AUDIO_BITS-1:0];
                        end
                    end else if (value <= step) begin
                        next_value = '0;
                        next_down  = 1'b0;
                    end else begin
                        next_value = value - step;
                    end
                end
            end
            MODE_SQR: next_value = (value != '0) ? '0 : MAX;
            default:  next_value = value;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            value <= RESET_VALUE;
            down  <= 1'b0;
        end else if (load) begin
            value <= next_value;
            down  <= next_down;
        end
    end

endmodule

// File: rtl/audio_tone_gen.sv
// rtl/audio_tone_gen.sv - multi-channel PCM test-pattern source with rate divider and handshake
module audio_tone_gen
    import audio_pkg::*;
#(
    parameter int AUDIO_BITS    = AUDIO_BITS_DEF,
    parameter int CHANNELS      = 2,
    parameter int DIV_BITS      = 26,
    parameter int PHASE_STAGGER = 1
) (
    input  logic                           clk,
    input  logic                           aclr,
    input  logic                           enable,
    input  logic [1:0]                     mode,
    input  logic [DIV_BITS-1:0]            divisor,
    input  logic [AUDIO_BITS-1:0]          step,
    input  logic                           overrun_clr,
    output logic [CHANNELS*AUDIO_BITS-1:0] pcm_out,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic                           overrun,
    output logic                           status
);

    localparam int SPACING = (1 << AUDIO_BITS) / CHANNELS;

    logic [DIV_BITS-1:0] count;
    logic [1:0]          mode_q;
    logic                tick;
    logic                gen;
    logic                drop;
    logic                xfer;

    assign tick = enable && (count >= divisor);
    assign xfer = sample_valid && sample_ready;
    // A tick either loads a fresh sample or, if the old one is still waiting, is dropped
    assign gen  = tick && (!sample_valid || sample_ready);
    assign drop = tick && sample_valid && !sample_ready;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            count        <= '0;
            mode_q       <= MODE_HOLD;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            status       <= 1'b0;
        end else begin
            mode_q <= mode;
            if (!enable || tick) begin
                count <= '0;
            end else begin
                count <= count + DIV_BITS'(1);
            end
            if (gen) begin
                sample_valid <= 1'b1;
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (gen) begin
                status <= ~status;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        localparam logic [AUDIO_BITS-1:0] RV =
            (PHASE_STAGGER != 0) ? AUDIO_BITS'(c * SPACING) : '0;

        audio_channel_gen #(
            .AUDIO_BITS  (AUDIO_BITS),
            .RESET_VALUE (RV)
        ) u_chan (
            .clk       (clk),
            .aclr      (aclr),
            .load      (gen),
            .dir_reset (mode_q != mode),
            .mode      (mode),
            .step      (step),
            .value     (pcm_out[c*AUDIO_BITS +: AUDIO_BITS])
        );
    end

endmodule

// File: tb/tb_audio_tone_gen.sv
// tb/tb_audio_tone_gen.sv - directed self-checking bench for audio_tone_gen
module tb_audio_tone_gen;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = MODE_SAW;
    logic [25:0] divisor = 26'd3;
    logic [11:0] step = 12'd127;
    logic        overrun_clr = 1'b0;
    logic        ready = 1'b1;

    logic [23:0] pcm;
    logic        valid, ovr, stat;
    logic [47:0] pcm4;
    logic        valid4, ovr4, stat4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_tone_gen u_dut (
        .clk(clk), .aclr(aclr), .enable(enable), .mode(mode), .divisor(divisor),
        .step(step), .overrun_clr(overrun_clr), .pcm_out(pcm), .sample_valid(valid),
        .sample_ready(ready), .overrun(ovr), .status(stat)
    );

    audio_tone_gen #(.CHANNELS(4)) u_dut4 (
        .clk(clk), .aclr(aclr), .enable(enable), .mode(mode), .divisor(divisor),
        .step(step), .overrun_clr(overrun_clr), .pcm_out(pcm4), .sample_valid(valid4),
        .sample_ready(ready), .overrun(ovr4), .status(stat4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) break;
        end
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        #2;
        aclr = 1'b0;
    endtask

    int n;
    int t2_ch0 [4] = '{1024, 2048, 3072, 0};
    int t2_ch1 [4] = '{3072, 0, 1024, 2048};
    int t3_ch0 [7] = '{1500, 3000, 4095, 2595, 1095, 0, 1500};
    int t3_ch1 [7] = '{3548, 4095, 2595, 1095, 0, 1500, 3000};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pcm", pcm, {12'd2048, 12'd0});
        chk("rst_valid", valid, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_status", stat, 0);
        chk("rst_pcm4", pcm4, {12'd3072, 12'd2048, 12'd1024, 12'd0});

        // SAW step 127, one sample every 4 cycles
        aclr = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            chk("t1_period", n, 4);
            chk("t1_ch0", pcm[11:0], 127 * (i + 1));
            chk("t1_ch1", pcm[23:12], 2048 + 127 * (i + 1));
            chk("t1_status", stat, (i + 1) % 2);
        end

        // SAW wrap
        step = 12'd1024;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            chk("t2_period", n, 4);
            chk("t2_ch0", pcm[11:0], t2_ch0[i]);
            chk("t2_ch1", pcm[23:12], t2_ch1[i]);
        end

        // TRIANGLE peak and floor
        mode = MODE_TRI;
        step = 12'd1500;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wait_valid(n);
            chk("t3_period", n, 4);
            chk("t3_ch0", pcm[11:0], t3_ch0[i]);
            chk("t3_ch1", pcm[23:12], t3_ch1[i]);
        end

        // Back-pressure and overrun
        mode = MODE_SAW;
        step = 12'd127;
        divisor = 26'd0;
        ready = 1'b0;
        do_reset();
        @(posedge clk); #1;
        chk("t4_valid", valid, 1);
        chk("t4_first", pcm[11:0], 127);
        chk("t4_ovr_first", ovr, 0);
        @(posedge clk); #1;
        chk("t4_hold1", pcm[11:0], 127);
        chk("t4_ovr_set", ovr, 1);
        @(posedge clk); #1;
        chk("t4_hold2", pcm[11:0], 127);
        overrun_clr = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_ovr_clr", ovr, 0);
        chk("t4_next", pcm[11:0], 254);
        chk("t4_valid2", valid, 1);
        ready = 1'b0;
        @(posedge clk); #1;
        chk("t4_set_wins", ovr, 1);
        chk("t4_hold3", pcm[11:0], 254);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("t4_clr_idle", ovr, 0);
        overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_dis_valid", valid, 1);
        chk("t4_dis_hold", pcm[11:0], 254);
        chk("t4_dis_ovr", ovr, 0);
        enable = 1'b1;
        ready = 1'b1;

        // SQUARE on four staggered channels
        mode = MODE_SQR;
        divisor = 26'd3;
        do_reset();
        wait_valid(n);
        chk("t5_period", n, 4);
        chk("t5_s1", pcm4, {12'd0, 12'd0, 12'd0, 12'd4095});
        wait_valid(n);
        chk("t5_period", n, 4);
        chk("t5_s2", pcm4, {12'd4095, 12'd4095, 12'd4095, 12'd0});

        // Asynchronous reset mid-count with a pending sample
        mode = MODE_SAW;
        ready = 1'b0;
        do_reset();
        wait_valid(n);
        chk("t6_period", n, 4);
        @(posedge clk);
        @(posedge clk);
        #3;
        aclr = 1'b1;
        #1;
        chk("t6_pcm", pcm, {12'd2048, 12'd0});
        chk("t6_valid", valid, 0);
        chk("t6_status", stat, 0);
        chk("t6_overrun", ovr, 0);
        #1;
        aclr = 1'b0;
        ready = 1'b1;
        wait_valid(n);
        chk("t6_restart", n, 4);
        chk("t6_ch0", pcm[11:0], 127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
